// File: rtl/batrider_gp9001_busctl.sv
// Turns 68000 bus cycles in the GP9001 and object-bank windows into one held GP9001 command.
// Start-to-DTACK is 2 cycles minimum; the CPU waits on DTACK for as long as the GCU withholds ACK (bounded by TIMEOUT).
module batrider_gp9001_busctl #(
  parameter int TIMEOUT    = 1023,
  parameter bit STATUS_INV = 1'b0
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        CPU_CS,
  input  logic        OBJBANK_CS,
  input  logic [2:0]  CPU_ADDR,
  input  logic        CPU_RNW,
  input  logic        CPU_UDS_N,
  input  logic        CPU_LDS_N,
  input  logic [15:0] CPU_DIN,
  output logic [15:0] CPU_DOUT,
  output logic        CPU_DTACK_N,
  input  logic        FBLANK,
  output logic        GP9001CS,
  input  logic        GP9001ACK,
  output logic [15:0] GP9001DIN,
  input  logic [15:0] GP9001DOUT,
  output logic        GP9001_OP_SELECT_REG,
  output logic        GP9001_OP_WRITE_REG,
  output logic        GP9001_OP_WRITE_RAM,
  output logic        GP9001_OP_READ_RAM_H,
  output logic        GP9001_OP_READ_RAM_L,
  output logic        GP9001_OP_SET_RAM_PTR,
  output logic        GP9001_OP_OBJECTBANK_WR,
  output logic [2:0]  GP9001_OBJECTBANK_SLOT,
  output logic        TIMEOUT_ERR
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DEC  = 2'd1;
  localparam logic [1:0] S_CMD  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  logic [1:0]    state;
  logic          sel_q;
  logic [2:0]    addr_q;
  logic          rnw_q;
  logic          obj_q;
  logic [6:0]    op;
  logic [CW-1:0] cnt;
  logic [6:0]    dec_op;
  logic          dec_status;
  logic          sel;
  logic          start;

  assign sel   = CPU_CS | OBJBANK_CS;
  assign start = sel & ~sel_q & (~CPU_UDS_N | ~CPU_LDS_N);

  // op bit order: 0 SELECT_REG, 1 WRITE_REG, 2 WRITE_RAM, 3 READ_RAM_H, 4 READ_RAM_L, 5 SET_RAM_PTR, 6 OBJECTBANK_WR
  assign GP9001_OP_SELECT_REG    = op[0];
  assign GP9001_OP_WRITE_REG     = op[1];
  assign GP9001_OP_WRITE_RAM     = op[2];
  assign GP9001_OP_READ_RAM_H    = op[3];
  assign GP9001_OP_READ_RAM_L    = op[4];
  assign GP9001_OP_SET_RAM_PTR   = op[5];
  assign GP9001_OP_OBJECTBANK_WR = op[6];

  // No op bit and no status flag means the access is answered locally as a null cycle.
  always_comb begin
    dec_op     = '0;
    dec_status = 1'b0;
    if (obj_q) begin
      if (!rnw_q) dec_op[6] = 1'b1;
    end else if (rnw_q) begin
      case (addr_q)
        3'd0:       dec_op[4]  = 1'b1;
        3'd1:       dec_op[3]  = 1'b1;
        3'd6, 3'd7: dec_status = 1'b1;
        default:    ;
      endcase
    end else begin
      case (addr_q)
        3'd0, 3'd1: dec_op[2] = 1'b1;
        3'd2, 3'd3: dec_op[5] = 1'b1;
        3'd4, 3'd5: dec_op[0] = 1'b1;
        3'd6:       dec_op[1] = 1'b1;
        default:    ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state                  <= S_IDLE;
      sel_q                  <= 1'b0;
      addr_q                 <= '0;
      rnw_q                  <= 1'b0;
      obj_q                  <= 1'b0;
      op                     <= '0;
      cnt                    <= '0;
      CPU_DOUT               <= '0;
      CPU_DTACK_N            <= 1'b1;
      GP9001CS               <= 1'b0;
      GP9001DIN              <= '0;
      GP9001_OBJECTBANK_SLOT <= '0;
      TIMEOUT_ERR            <= 1'b0;
    end else begin
      sel_q       <= sel;
      TIMEOUT_ERR <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            addr_q    <= CPU_ADDR;
            rnw_q     <= CPU_RNW;
            obj_q     <= OBJBANK_CS;
            GP9001DIN <= OBJBANK_CS ? {8'h00, CPU_DIN[7:0]} : CPU_DIN;
            cnt       <= '0;
            state     <= S_DEC;
          end
        end
        S_DEC: begin
          if (dec_op != '0) begin
            op       <= dec_op;
            GP9001CS <= 1'b1;
            if (obj_q) GP9001_OBJECTBANK_SLOT <= addr_q;
            state    <= S_CMD;
          end else begin
            if (rnw_q) CPU_DOUT <= dec_status ? {15'b0, FBLANK ^ STATUS_INV} : 16'hFFFF;
            CPU_DTACK_N <= 1'b0;
            state       <= S_DONE;
          end
        end
        S_CMD: begin
          if (GP9001ACK) begin
            if (rnw_q) CPU_DOUT <= GP9001DOUT;
            op          <= '0;
            GP9001CS    <= 1'b0;
            CPU_DTACK_N <= 1'b0;
            state       <= S_DONE;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            if (rnw_q) CPU_DOUT <= 16'hFFFF;
            op          <= '0;
            GP9001CS    <= 1'b0;
            CPU_DTACK_N <= 1'b0;
            TIMEOUT_ERR <= 1'b1;
            state       <= S_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          // Hold DTACK until the CPU ends its cycle so no second command is launched.
          if (!sel) begin
            CPU_DTACK_N <= 1'b1;
            state       <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_batrider_gp9001_busctl.sv
// Randomized bench for batrider_gp9001_busctl against a table-driven transaction model.
module tb_batrider_gp9001_busctl;

  localparam int TMO  = 8;
  localparam bit SINV = 1'b0;

  localparam int OP_SEL = 0, OP_WREG = 1, OP_WRAM = 2, OP_RDH = 3, OP_RDL = 4, OP_PTR = 5, OP_OBJ = 6;
  localparam int K_STATUS = 7, K_NULL = 8;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        CPU_CS, OBJBANK_CS;
  logic [2:0]  CPU_ADDR;
  logic        CPU_RNW, CPU_UDS_N, CPU_LDS_N;
  logic [15:0] CPU_DIN;
  logic [15:0] CPU_DOUT;
  logic        CPU_DTACK_N;
  logic        FBLANK;
  logic        GP9001CS, GP9001ACK;
  logic [15:0] GP9001DIN, GP9001DOUT;
  logic        op_sel, op_wreg, op_wram, op_rdh, op_rdl, op_ptr, op_obj;
  logic [2:0]  slot;
  logic        TIMEOUT_ERR;

  int n_vec = 0;
  int n_err = 0;
  logic [15:0] exp_dout = 16'h0000;

  // Address-indexed command tables for the GP9001 window.
  int wr_map [8] = '{OP_WRAM, OP_WRAM, OP_PTR, OP_PTR, OP_SEL, OP_SEL, OP_WREG, K_NULL};
  int rd_map [8] = '{OP_RDL, OP_RDH, K_NULL, K_NULL, K_NULL, K_NULL, K_STATUS, K_STATUS};

  always #5 CLK = ~CLK;

  batrider_gp9001_busctl #(.TIMEOUT(TMO), .STATUS_INV(SINV)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .CPU_CS(CPU_CS), .OBJBANK_CS(OBJBANK_CS),
    .CPU_ADDR(CPU_ADDR), .CPU_RNW(CPU_RNW), .CPU_UDS_N(CPU_UDS_N), .CPU_LDS_N(CPU_LDS_N),
    .CPU_DIN(CPU_DIN), .CPU_DOUT(CPU_DOUT), .CPU_DTACK_N(CPU_DTACK_N), .FBLANK(FBLANK),
    .GP9001CS(GP9001CS), .GP9001ACK(GP9001ACK), .GP9001DIN(GP9001DIN), .GP9001DOUT(GP9001DOUT),
    .GP9001_OP_SELECT_REG(op_sel), .GP9001_OP_WRITE_REG(op_wreg), .GP9001_OP_WRITE_RAM(op_wram),
    .GP9001_OP_READ_RAM_H(op_rdh), .GP9001_OP_READ_RAM_L(op_rdl), .GP9001_OP_SET_RAM_PTR(op_ptr),
    .GP9001_OP_OBJECTBANK_WR(op_obj), .GP9001_OBJECTBANK_SLOT(slot), .TIMEOUT_ERR(TIMEOUT_ERR)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [6:0] obs_ops();
    return {op_obj, op_ptr, op_rdl, op_rdh, op_wram, op_wreg, op_sel};
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cs"},    32'(GP9001CS), 32'd0);
    check({tag, "_ops"},   32'(obs_ops()), 32'd0);
    check({tag, "_dtack"}, 32'(CPU_DTACK_N), 32'd1);
    check({tag, "_dout"},  32'(CPU_DOUT), 32'd0);
    check({tag, "_din"},   32'(GP9001DIN), 32'd0);
    check({tag, "_slot"},  32'(slot), 32'd0);
    check({tag, "_err"},   32'(TIMEOUT_ERR), 32'd0);
  endtask

  // One CPU bus cycle. ack_at = CS-high cycle in which the GCU acks (0 = never).
  task automatic run_txn(input logic cs, input logic ob, input logic [2:0] a, input logic rnw,
                         input logic [1:0] strb_n, input logic [15:0] din, input logic fb,
                         input int ack_at, input logic [15:0] ack_val, input logic early, input int hold);
    int kind, exp_cs, exp_lat, lat, cs_cyc, errs;
    logic tmo, remote, sel_on;
    logic [15:0] exp_din;
    kind    = ob ? (rnw ? K_NULL : OP_OBJ) : (rnw ? rd_map[a] : wr_map[a]);
    exp_din = ob ? {8'h00, din[7:0]} : din;
    remote  = (kind < K_STATUS);
    tmo     = remote && (ack_at == 0 || ack_at > TMO);
    exp_cs  = !remote ? 0 : (tmo ? TMO : ack_at);
    exp_lat = exp_cs + 1;
    if (rnw) begin
      if (kind == K_STATUS)         exp_dout = {15'b0, fb ^ SINV};
      else if (kind == K_NULL || tmo) exp_dout = 16'hFFFF;
      else                          exp_dout = ack_val;
    end

    CPU_CS = cs; OBJBANK_CS = ob; CPU_ADDR = a; CPU_RNW = rnw;
    {CPU_UDS_N, CPU_LDS_N} = strb_n; CPU_DIN = din; FBLANK = fb; GP9001ACK = 1'b0;
    lat = -1; cs_cyc = 0; errs = 0; sel_on = 1'b1;

    for (int n = 1; n <= 40 && lat < 0; n++) begin
      @(negedge CLK);
      GP9001ACK  = 1'b0;
      GP9001DOUT = 16'($urandom);
      if (TIMEOUT_ERR) errs++;
      if (GP9001CS) begin
        cs_cyc++;
        check("op_onehot", 32'(obs_ops()), 32'(7'd1 << kind));
        check("gp_din", 32'(GP9001DIN), 32'(exp_din));
        if (ob) check("slot", 32'(slot), 32'(a));
        if (cs_cyc == ack_at) begin
          GP9001ACK  = 1'b1;
          GP9001DOUT = ack_val;
        end
      end else begin
        check("op_idle", 32'(obs_ops()), 32'd0);
      end
      if (!CPU_DTACK_N) lat = n - 1;
      else if (early && n == 1) begin
        CPU_CS = 1'b0; OBJBANK_CS = 1'b0; sel_on = 1'b0;
      end
    end

    check("dtack_latency", 32'(lat), 32'(exp_lat));
    check("cs_cycles", 32'(cs_cyc), 32'(exp_cs));
    check("cpu_dout", 32'(CPU_DOUT), 32'(exp_dout));

    if (sel_on) begin
      for (int h = 0; h < hold; h++) begin
        @(negedge CLK);
        if (TIMEOUT_ERR) errs++;
        check("dtack_hold", 32'(CPU_DTACK_N), 32'd0);
        check("cs_in_done", 32'(GP9001CS), 32'd0);
      end
      CPU_CS = 1'b0; OBJBANK_CS = 1'b0;
    end
    @(negedge CLK);
    if (TIMEOUT_ERR) errs++;
    check("dtack_release", 32'(CPU_DTACK_N), 32'd1);
    check("timeout_pulses", 32'(errs), 32'(tmo));
    {CPU_UDS_N, CPU_LDS_N} = 2'b11;
  endtask

  // Idle gap with stray ACK pulses that must be ignored.
  task automatic idle_gap(input int cycles);
    for (int g = 0; g < cycles; g++) begin
      GP9001ACK = 1'($urandom_range(0, 1));
      @(negedge CLK);
      check("gap_dtack", 32'(CPU_DTACK_N), 32'd1);
      check("gap_cs", 32'(GP9001CS), 32'd0);
    end
    GP9001ACK = 1'b0;
  endtask

  initial begin
    logic [1:0] strb;
    int         which;
    RESET_N = 1'b0; CPU_CS = 1'b0; OBJBANK_CS = 1'b0; CPU_ADDR = '0; CPU_RNW = 1'b1;
    CPU_UDS_N = 1'b1; CPU_LDS_N = 1'b1; CPU_DIN = '0; FBLANK = 1'b0;
    GP9001ACK = 1'b0; GP9001DOUT = '0;
    repeat (3) @(negedge CLK);
    check_reset_outputs("reset");
    RESET_N = 1'b1;
    @(negedge CLK);

    run_txn(1'b1, 1'b0, 3'd0, 1'b0, 2'b00, 16'h1234, 1'b0, 3, 16'h0000, 1'b0, 0);
    idle_gap(2);
    run_txn(1'b1, 1'b0, 3'd1, 1'b1, 2'b00, 16'h0000, 1'b0, 2, 16'hBEEF, 1'b0, 1);
    idle_gap(1);
    run_txn(1'b0, 1'b1, 3'd5, 1'b0, 2'b10, 16'hAB07, 1'b0, 1, 16'h0000, 1'b0, 0);
    run_txn(1'b1, 1'b0, 3'd7, 1'b1, 2'b00, 16'h0000, 1'b1, 1, 16'h0000, 1'b0, 2);
    run_txn(1'b1, 1'b0, 3'd0, 1'b1, 2'b00, 16'h0000, 1'b0, 0, 16'h0000, 1'b0, 0);
    run_txn(1'b1, 1'b1, 3'd3, 1'b0, 2'b01, 16'h5A5A, 1'b0, 1, 16'h0000, 1'b0, 0);
    run_txn(1'b1, 1'b0, 3'd0, 1'b1, 2'b00, 16'h0000, 1'b0, 4, 16'hC0DE, 1'b1, 0);
    run_txn(1'b1, 1'b0, 3'd3, 1'b1, 2'b00, 16'h0000, 1'b0, 1, 16'h0000, 1'b0, 0);
    run_txn(1'b1, 1'b0, 3'd7, 1'b0, 2'b00, 16'h7777, 1'b0, 1, 16'h0000, 1'b0, 0);

    for (int i = 0; i < 150; i++) begin
      which = $urandom_range(0, 3);
      strb  = 2'($urandom_range(0, 2));
      run_txn(which != 1, which == 1 || which == 3, 3'($urandom), 1'($urandom),
              strb, 16'($urandom), 1'($urandom), $urandom_range(0, 11), 16'($urandom),
              ($urandom_range(0, 4) == 0), $urandom_range(0, 2));
      idle_gap($urandom_range(0, 2));
    end

    // Select without any data strobe must not start a cycle.
    CPU_CS = 1'b1; CPU_UDS_N = 1'b1; CPU_LDS_N = 1'b1; CPU_RNW = 1'b1; CPU_ADDR = 3'd1;
    repeat (4) begin
      @(negedge CLK);
      check("nostrobe_dtack", 32'(CPU_DTACK_N), 32'd1);
      check("nostrobe_cs", 32'(GP9001CS), 32'd0);
    end
    CPU_CS = 1'b0;
    @(negedge CLK);

    // Reset while a command is waiting for ACK; a late ACK must be ignored.
    CPU_CS = 1'b1; CPU_ADDR = 3'd0; CPU_RNW = 1'b1; CPU_UDS_N = 1'b0; CPU_LDS_N = 1'b0;
    repeat (4) @(negedge CLK);
    check("pre_reset_cs", 32'(GP9001CS), 32'd1);
    RESET_N = 1'b0;
    @(negedge CLK);
    check_reset_outputs("midreset");
    CPU_CS = 1'b0; CPU_UDS_N = 1'b1; CPU_LDS_N = 1'b1;
    GP9001ACK = 1'b1; GP9001DOUT = 16'h1111;
    @(negedge CLK);
    GP9001ACK = 1'b0;
    RESET_N = 1'b1;
    GP9001ACK = 1'b1;
    @(negedge CLK);
    GP9001ACK = 1'b0;
    repeat (3) begin
      @(negedge CLK);
      check("post_reset_dtack", 32'(CPU_DTACK_N), 32'd1);
      check("post_reset_cs", 32'(GP9001CS), 32'd0);
      check("post_reset_dout", 32'(CPU_DOUT), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
